// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared definitions for the convolutional block-floating-point normaliser.
//   redundant_sign_bits : headroom of a sign-extended sample of a given width
//   play_state_e        : playout FSM states
//   ROUND_ONE           : unit rounding increment, scaled by the top level to the half-LSB
// Optional feature macro used by the top level: CBFP_ROUND_EN.
package cbfp_pkg;

  // Widest sample the headroom function accepts; callers sign-extend to this width.
  localparam int unsigned RSB_MAX_W = 64;

  localparam logic [RSB_MAX_W-1:0] ROUND_ONE = 64'd1;

  typedef enum logic [0:0] {IDLE, PLAY} play_state_e;

  // Count of leading bits equal to the sign bit, minus one, for a w-bit value that has
  // been sign-extended to RSB_MAX_W. The extension adds exactly RSB_MAX_W-w copies.
  function automatic int unsigned redundant_sign_bits(input logic [RSB_MAX_W-1:0] x,
                                                      input int unsigned w);
    int unsigned cnt;
    logic        run;
    cnt = 0;
    run = 1'b1;
    for (int i = RSB_MAX_W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[RSB_MAX_W-1])) begin
        cnt++;
      end else begin
        run = 1'b0;
      end
    end
    return cnt - (RSB_MAX_W - w);
  endfunction

endpackage

// File: rtl/cbfp_headroom.sv
// cbfp_headroom: combinational beat headroom.
//   smp_re, smp_im : LANES signed samples each (real / imaginary)
//   beat_min       : smallest headroom over all 2*LANES samples (0..IN_WIDTH-1)
module cbfp_headroom
  import cbfp_pkg::*;
#(
  parameter int unsigned LANES    = 16,
  parameter int unsigned IN_WIDTH = 25
) (
  input  logic signed [IN_WIDTH-1:0]         smp_re [0:LANES-1],
  input  logic signed [IN_WIDTH-1:0]         smp_im [0:LANES-1],
  output logic        [$clog2(IN_WIDTH)-1:0] beat_min
);

  localparam int unsigned HrWidth = $clog2(IN_WIDTH);

  always_comb begin
    int unsigned m;
    int unsigned h_re;
    int unsigned h_im;
    m = IN_WIDTH - 1;
    for (int l = 0; l < int'(LANES); l++) begin
      h_re = redundant_sign_bits(RSB_MAX_W'(smp_re[l]), IN_WIDTH);
      h_im = redundant_sign_bits(RSB_MAX_W'(smp_im[l]), IN_WIDTH);
      if (h_re < m) m = h_re;
      if (h_im < m) m = h_im;
    end
    beat_min = HrWidth'(m);
  end

endmodule

// File: rtl/cbfp_block_norm.sv
// cbfp_block_norm: multi-beat block-floating-point normaliser with ping-pong banks.
//   clk, rstn          : clock, synchronous active-low reset
//   din_valid          : input beat valid (no backpressure)
//   din_i, din_q       : LANES signed IN_WIDTH samples (real / imaginary)
//   valid_out          : output beat valid
//   dout_i, dout_q     : LANES signed OUT_WIDTH normalised samples
//   shift_index        : common left shift of the current block
//   blk_start          : first output beat of a block
// Macro CBFP_ROUND_EN: round half up with positive saturation instead of truncation.
module cbfp_block_norm
  import cbfp_pkg::*;
#(
  parameter int unsigned LANES       = 16,
  parameter int unsigned IN_WIDTH    = 25,
  parameter int unsigned OUT_WIDTH   = 12,
  parameter int unsigned GROUP_BEATS = 4,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned MAX_SHIFT   = IN_WIDTH - 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  input  logic signed [IN_WIDTH-1:0]    din_i [0:LANES-1],
  input  logic signed [IN_WIDTH-1:0]    din_q [0:LANES-1],
  output logic                          valid_out,
  output logic signed [OUT_WIDTH-1:0]   dout_i [0:LANES-1],
  output logic signed [OUT_WIDTH-1:0]   dout_q [0:LANES-1],
  output logic        [SHIFT_WIDTH-1:0] shift_index,
  output logic                          blk_start
);

  localparam int unsigned HrWidth = $clog2(IN_WIDTH);
  localparam int unsigned CntW    = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;
  localparam int unsigned AddrW   = $clog2(2 * GROUP_BEATS);
  localparam int unsigned Drop    = IN_WIDTH - OUT_WIDTH;
  localparam logic [CntW-1:0]    LastBeat = CntW'(GROUP_BEATS - 1);
  localparam logic [HrWidth-1:0] HrMax    = HrWidth'(IN_WIDTH - 1);
`ifdef CBFP_ROUND_EN
  localparam logic [IN_WIDTH:0] RoundAdd = (IN_WIDTH + 1)'(ROUND_ONE << (Drop - 1));
`endif

  // Two banks of GROUP_BEATS beats; bank b occupies rows b*GROUP_BEATS onward.
  logic signed [IN_WIDTH-1:0] mem_re [0:2*GROUP_BEATS-1][0:LANES-1];
  logic signed [IN_WIDTH-1:0] mem_im [0:2*GROUP_BEATS-1][0:LANES-1];

  logic [CntW-1:0]        wr_cnt;
  logic                   wr_bank;
  logic [AddrW-1:0]       wr_addr;
  logic [HrWidth-1:0]     run_min;
  logic [HrWidth-1:0]     beat_min;
  logic [HrWidth-1:0]     new_min;
  logic [SHIFT_WIDTH-1:0] blk_shift;
  logic [SHIFT_WIDTH-1:0] shift_reg [0:1];
  logic                   wr_last;

  logic [1:0]             full;
  logic [1:0]             full_d;
  logic [1:0]             full_set;
  logic [1:0]             full_clr;

  play_state_e            state, state_d;
  logic                   rd_bank, rd_bank_d;
  logic [CntW-1:0]        rd_cnt, rd_cnt_d;
  logic [AddrW-1:0]       rd_addr;
  logic                   issue;

  // ---------------- input side ----------------

  cbfp_headroom #(
    .LANES   (LANES),
    .IN_WIDTH(IN_WIDTH)
  ) u_headroom (
    .smp_re  (din_i),
    .smp_im  (din_q),
    .beat_min(beat_min)
  );

  always_comb begin
    new_min   = (beat_min < run_min) ? beat_min : run_min;
    blk_shift = (int'(new_min) > int'(MAX_SHIFT)) ? SHIFT_WIDTH'(MAX_SHIFT)
                                                  : SHIFT_WIDTH'(new_min);
    wr_last   = din_valid && (wr_cnt == LastBeat);
    wr_addr   = AddrW'(wr_bank ? GROUP_BEATS : 0) + AddrW'(wr_cnt);
    rd_addr   = AddrW'(rd_bank ? GROUP_BEATS : 0) + AddrW'(rd_cnt);
  end

  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < int'(LANES); l++) begin
        mem_re[wr_addr][l] <= din_i[l];
        mem_im[wr_addr][l] <= din_q[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_cnt       <= '0;
      wr_bank      <= 1'b0;
      run_min      <= HrMax;
      shift_reg[0] <= '0;
      shift_reg[1] <= '0;
    end else if (din_valid) begin
      if (wr_last) begin
        shift_reg[wr_bank] <= blk_shift;
        wr_cnt             <= '0;
        wr_bank            <= ~wr_bank;
        run_min            <= HrMax;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
        run_min <= new_min;
      end
    end
  end

  // ---------------- bank occupancy ----------------

  always_comb begin
    full_set          = '0;
    full_set[wr_bank] = wr_last;
    full_d            = (full & ~full_clr) | full_set;
  end

  always_ff @(posedge clk) begin
    if (!rstn) full <= '0;
    else       full <= full_d;
  end

  // ---------------- playout FSM ----------------

  // Beat 0 is issued in the same cycle IDLE sees the full bank, so the first output
  // lands two cycles after the last input beat.
  always_comb begin
    state_d   = state;
    rd_bank_d = rd_bank;
    rd_cnt_d  = rd_cnt;
    issue     = 1'b0;
    full_clr  = '0;
    unique case (state)
      IDLE:    issue = full[rd_bank];
      PLAY:    issue = 1'b1;
      default: issue = 1'b0;
    endcase
    if (issue) begin
      if (rd_cnt == LastBeat) begin
        full_clr[rd_bank] = 1'b1;
        rd_bank_d         = ~rd_bank;
        rd_cnt_d          = '0;
        state_d           = full[~rd_bank] ? PLAY : IDLE;
      end else begin
        rd_cnt_d = rd_cnt + 1'b1;
        state_d  = PLAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_d;
      rd_bank <= rd_bank_d;
      rd_cnt  <= rd_cnt_d;
    end
  end

  // ---------------- shift / round datapath ----------------

  function automatic logic signed [OUT_WIDTH-1:0] norm(input logic signed [IN_WIDTH-1:0] x,
                                                       input logic [SHIFT_WIDTH-1:0] s);
    logic signed [IN_WIDTH-1:0] sh;
`ifdef CBFP_ROUND_EN
    logic [IN_WIDTH:0]  sum;
    logic [OUT_WIDTH:0] top;
`endif
    sh = x <<< s;
`ifdef CBFP_ROUND_EN
    sum = {sh[IN_WIDTH-1], sh} + RoundAdd;
    top = sum[IN_WIDTH:Drop];
    // Adding a positive constant can only overflow upwards.
    if (top[OUT_WIDTH] != top[OUT_WIDTH-1]) return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    return top[OUT_WIDTH-1:0];
`else
    return sh[IN_WIDTH-1:Drop];
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn || !issue) begin
      valid_out   <= 1'b0;
      blk_start   <= 1'b0;
      shift_index <= '0;
      for (int l = 0; l < int'(LANES); l++) begin
        dout_i[l] <= '0;
        dout_q[l] <= '0;
      end
    end else begin
      valid_out   <= 1'b1;
      blk_start   <= (rd_cnt == '0);
      shift_index <= shift_reg[rd_bank];
      for (int l = 0; l < int'(LANES); l++) begin
        dout_i[l] <= norm(mem_re[rd_addr][l], shift_reg[rd_bank]);
        dout_q[l] <= norm(mem_im[rd_addr][l], shift_reg[rd_bank]);
      end
    end
  end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// tb_cbfp_block_norm: directed self-checking bench for cbfp_block_norm (default parameters,
// plus a second instance with MAX_SHIFT=10). Expected values follow CBFP_ROUND_EN if defined.
module tb_cbfp_block_norm;

  localparam int L  = 16;
  localparam int IW = 25;
  localparam int OW = 12;
  localparam int SW = 5;

`ifdef CBFP_ROUND_EN
  localparam int Rnd4096 = 1;
`else
  localparam int Rnd4096 = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [IW-1:0] din_i [0:L-1];
  logic signed [IW-1:0] din_q [0:L-1];
  logic                 valid_out, blk_start;
  logic signed [OW-1:0] dout_i [0:L-1];
  logic signed [OW-1:0] dout_q [0:L-1];
  logic [SW-1:0]        shift_index;
  logic                 valid2, blk2;
  logic signed [OW-1:0] dout2_i [0:L-1];
  logic signed [OW-1:0] dout2_q [0:L-1];
  logic [SW-1:0]        shift2;

  cbfp_block_norm u_dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q), .shift_index(shift_index),
    .blk_start(blk_start)
  );

  cbfp_block_norm #(.MAX_SHIFT(10)) u_dut_ms (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .valid_out(valid2), .dout_i(dout2_i), .dout_q(dout2_q), .shift_index(shift2),
    .blk_start(blk2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int              cyc;
    int              sh;
    int              bs;
    logic [L*OW-1:0] di;
    logic [L*OW-1:0] dq;
  } beat_t;

  beat_t cap[$];
  beat_t cap2[$];
  beat_t ref_q[$];
  int    zero_viol = 0;

  always @(negedge clk) begin
    beat_t b;
    b.cyc = cyc;
    b.sh  = int'(shift_index);
    b.bs  = int'(blk_start);
    for (int l = 0; l < L; l++) begin
      b.di[l*OW +: OW] = dout_i[l];
      b.dq[l*OW +: OW] = dout_q[l];
    end
    if (valid_out) cap.push_back(b);
    else if (b.sh != 0 || b.bs != 0 || b.di != '0 || b.dq != '0) zero_viol++;
    b.sh = int'(shift2);
    b.bs = int'(blk2);
    for (int l = 0; l < L; l++) begin
      b.di[l*OW +: OW] = dout2_i[l];
      b.dq[l*OW +: OW] = dout2_q[l];
    end
    if (valid2) cap2.push_back(b);
  end

  int checks = 0;
  int errors = 0;
  int last_in = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [L*OW-1:0] f, input int l);
    logic signed [OW-1:0] v;
    v = f[l*OW +: OW];
    return int'(v);
  endfunction

  // All lanes get base; optional single real lane li and imaginary lane lq override.
  task automatic beat(input int base, input int li, input int vi, input int lq, input int vq);
    for (int l = 0; l < L; l++) begin
      din_i[l] = IW'(base);
      din_q[l] = IW'(base);
    end
    if (li >= 0) din_i[li] = IW'(vi);
    if (lq >= 0) din_q[lq] = IW'(vq);
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    last_in = cyc - 1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Block b: s = 23-b; lane 0 gives 2^(10-b), real lane 3 of beat 2 gives 1024.
  task automatic send_block(input int b, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if (k == 2) beat(1, 3, 1 << b, -1, 0);
      else        beat(1, -1, 0, -1, 0);
    end
  endtask

  int t0;

  initial begin
    for (int l = 0; l < L; l++) begin
      din_i[l] = '0;
      din_q[l] = '0;
    end
    idle(3);
    @(negedge clk);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_shift", int'(shift_index), 0);
    chk("rst_blk_start", int'(blk_start), 0);
    chk("rst_dout", int'(dout_i[0]), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    // All ones: s=23, every sample 1024.
    cap.delete();
    cap2.delete();
    repeat (4) beat(1, -1, 0, -1, 0);
    idle(8);
    chk("ones_count", cap.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("ones_cycle", cap[k].cyc, last_in + 2 + k);
      chk("ones_shift", cap[k].sh, 23);
      chk("ones_blk_start", cap[k].bs, (k == 0) ? 1 : 0);
      chk("ones_dout_i0", lane(cap[k].di, 0), 1024);
      chk("ones_dout_q15", lane(cap[k].dq, 15), 1024);
    end
    chk("clamp_count", cap2.size(), 4);
    chk("clamp_shift", cap2[0].sh, 10);
    chk("clamp_dout", lane(cap2[0].di, 0), 0);

    // All zeros: s=24, every sample 0.
    cap.delete();
    cap2.delete();
    repeat (4) beat(0, -1, 0, -1, 0);
    idle(8);
    chk("zeros_count", cap.size(), 4);
    chk("zeros_shift", cap[0].sh, 24);
    chk("zeros_dout_i5", lane(cap[1].di, 5), 0);
    chk("zeros_dout_q9", lane(cap[3].dq, 9), 0);
    chk("zeros_clamp_shift", cap2[2].sh, 10);

    // Full-scale: -2^24 and 2^24-1 force s=0.
    cap.delete();
    cap2.delete();
    beat(4096, 0, -(1 << 24), 1, (1 << 24) - 1);
    repeat (3) beat(4096, -1, 0, -1, 0);
    idle(8);
    chk("fs_count", cap.size(), 4);
    chk("fs_shift", cap[0].sh, 0);
    chk("fs_neg_full", lane(cap[0].di, 0), -2048);
    chk("fs_pos_full", lane(cap[0].dq, 1), 2047);
    chk("fs_4096_i2", lane(cap[0].di, 2), Rnd4096);
    chk("fs_4096_q15", lane(cap[3].dq, 15), Rnd4096);
    chk("fs_clamp_shift", cap2[0].sh, 0);

    // Continuous: eight back-to-back blocks with s = 23..16.
    cap.delete();
    for (int b = 0; b < 8; b++) begin
      send_block(b, 1'b0);
      if (b == 0) t0 = last_in;
    end
    idle(10);
    chk("cont_count", cap.size(), 32);
    for (int k = 0; k < 32; k++) begin
      chk("cont_cycle", cap[k].cyc, t0 + 2 + k);
      chk("cont_blk_start", cap[k].bs, (k % 4 == 0) ? 1 : 0);
      chk("cont_shift", cap[k].sh, 23 - k / 4);
      if (k % 4 == 0) chk("cont_lane0", lane(cap[k].di, 0), 1 << (10 - k / 4));
      if (k % 4 == 2) chk("cont_lane3", lane(cap[k].di, 3), 1024);
    end
    ref_q = cap;

    // Gapped: same content, each output block contiguous.
    cap.delete();
    for (int b = 0; b < 8; b++) send_block(b, 1'b1);
    idle(20);
    chk("gap_count", cap.size(), 32);
    for (int k = 0; k < 32; k++) begin
      chk("gap_di", int'(cap[k].di == ref_q[k].di), 1);
      chk("gap_dq", int'(cap[k].dq == ref_q[k].dq), 1);
      chk("gap_shift", cap[k].sh, ref_q[k].sh);
      chk("gap_blk_start", cap[k].bs, ref_q[k].bs);
      if (k % 4 != 0) chk("gap_contiguous", cap[k].cyc, cap[k-1].cyc + 1);
    end

    // Reset while block A plays out and block B is three beats in.
    cap.delete();
    repeat (4) beat(1, -1, 0, -1, 0);
    repeat (3) beat(1 << 20, -1, 0, -1, 0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(valid_out), 0);
    chk("rst_mid_dout", int'(dout_i[0]), 0);
    chk("rst_mid_played", cap.size(), 3);
    @(posedge clk);
    #1;
    cap.delete();
    repeat (4) beat(3, -1, 0, -1, 0);
    idle(10);
    chk("fresh_count", cap.size(), 4);
    chk("fresh_cycle", cap[0].cyc, last_in + 2);
    chk("fresh_blk_start", cap[0].bs, 1);
    chk("fresh_shift", cap[0].sh, 22);
    chk("fresh_dout", lane(cap[2].di, 7), 1536);

    chk("zero_when_idle", zero_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbfp_block_norm.md
# cbfp_block_norm

Parametrised convolutional block-floating-point (CBFP) normaliser for the parallel FFT pipeline. It groups `GROUP_BEATS` consecutive valid beats of `LANES` complex samples into one block and finds the smallest redundant-sign-bit count over every real and imaginary sample in the block. It then replays the buffered block with one common left shift, reduced to `OUT_WIDTH`. It sits between a butterfly stage and the next stage and generalises per-beat normalisation to multi-beat blocks, with ping-pong buffering and optional rounding.

## Interface

Parameters:

- `LANES`, 16: complex samples per beat.
- `IN_WIDTH`, 25: signed input width.
- `OUT_WIDTH`, 12: signed output width; must satisfy `OUT_WIDTH < IN_WIDTH`.
- `GROUP_BEATS`, 4: beats per CBFP block; must be ≥ 1.
- `SHIFT_WIDTH`, 5: width of the shift index; must satisfy `2^SHIFT_WIDTH > MAX_SHIFT`.
- `MAX_SHIFT`, `IN_WIDTH-1`: upper clamp on the block shift.

Ports:

- `clk`, input, 1: sole clock. Reset is synchronous and active-low.
- `rstn`, input, 1: synchronous active-low reset.
- `din_valid`, input, 1: input beat valid. There is no backpressure.
- `din_i[0:LANES-1]`, input, `IN_WIDTH` each, signed: real lanes.
- `din_q[0:LANES-1]`, input, `IN_WIDTH` each, signed: imaginary lanes.
- `valid_out`, output, 1: output beat valid.
- `dout_i[0:LANES-1]`, output, `OUT_WIDTH` each, signed: normalised real lanes.
- `dout_q[0:LANES-1]`, output, `OUT_WIDTH` each, signed: normalised imaginary lanes.
- `shift_index`, output, `SHIFT_WIDTH`: block shift `s`, held constant for every beat of the block.
- `blk_start`, output, 1: high on the first output beat of each block.

## Operation

- Headroom `h(x)` is the count of leading bits equal to the sign bit, minus 1. Its range is 0..`IN_WIDTH-1`. Zero and -1 give `IN_WIDTH-1`.
- Block shift: `s = min(MAX_SHIFT, min over all 2*LANES*GROUP_BEATS samples of h)`.
- Output sample without rounding: `y = (x <<< s)[IN_WIDTH-1 : IN_WIDTH-OUT_WIDTH]`, i.e. arithmetic truncation.
- Input side:
  - `wr_cnt` runs 0..`GROUP_BEATS-1` and advances only on `din_valid`.
  - Each beat is written to bank `wr_bank`, and a running-minimum register is updated.
  - On the last beat: latch `s` into that bank's shift register, mark the bank full, toggle `wr_bank`, and clear the running minimum to `IN_WIDTH-1`.
  - Gaps in `din_valid` are allowed anywhere inside a block.
- Output FSM:
  - IDLE: when a bank is full, go to PLAY with `rd_bank` set to that bank and `rd_cnt` = 0.
  - PLAY: emit one beat per cycle, back to back, for `GROUP_BEATS` cycles. After the last beat, clear the bank's full flag. Then go to IDLE, or stay in PLAY on the other bank if it is already full, with no bubble.
- Ping-pong sufficiency: input needs at least `GROUP_BEATS` cycles per block and output uses exactly `GROUP_BEATS`, so a bank is always free before the next block finishes. No overflow path exists.
- Reset: all outputs are 0, counters and flags are cleared, banks are empty, and the running minimum is `IN_WIDTH-1`.
  - Reset asserted mid-block or mid-playout discards all partial and buffered data.
  - The first valid beat after reset is beat 0 of a new block.

## Timing

- If the last beat of a block is accepted in cycle t, `valid_out` with `blk_start`=1 is asserted in cycle t+2. Beats k = 0..`GROUP_BEATS-1` appear in cycles t+2+k.
- The last input beat's headroom is included in `s`: it is computed combinationally and registered at the edge ending cycle t.
- Outputs are registered. `shift_index` is valid whenever `valid_out`=1. `dout_*`, `shift_index` and `blk_start` are 0 when `valid_out`=0.
- A write and a read of different banks in the same cycle are legal. A new block's beat 0 may arrive in cycle t+1.

## Configuration

- `CBFP_ROUND_EN` defined:
  - Add `2^(IN_WIDTH-OUT_WIDTH-1)` to `x <<< s` before taking the top bits (round half up).
  - Saturate to `2^(OUT_WIDTH-1)-1` on positive overflow.
  - Latency is unchanged; the adder sits in the same output register stage.
- `CBFP_ROUND_EN` undefined: pure truncation as in Operation.

## Structure

- Package `cbfp_pkg` holds:
  - the `redundant_sign_bits` function, parametrised by width through a `localparam` wrapper;
  - the FSM state enum `{IDLE, PLAY}`;
  - a `localparam` for the rounding constant.
- Sub-module `cbfp_headroom`: combinational per-sample headroom plus a min-tree over `2*LANES` values, producing the beat minimum. It is instantiated once.
- The top level holds the banks (registers, `2*GROUP_BEATS` beats), the counters, the FSM and the shift/round datapath.

## Test plan

All scenarios use the default parameters.

- **All ones.** Block of all samples = 1 → `s`=23, every `dout` = 1024, and `shift_index`=23 on 4 beats, the first arriving 2 cycles after the last input.
- **All zeros.** All-zero block → `s`=24, every `dout` = 0. Then set `MAX_SHIFT`=10 and apply a block of all samples = 1 → `s`=10, `dout` = 0.
- **Full-scale sample with truncation.** One sample = -2^24 and the rest = 4096 → `s`=0. The full-scale sample gives `dout` = -2048 and the others give 0 (truncation). With `CBFP_ROUND_EN`, the 4096 samples give 1. With `CBFP_ROUND_EN` and one sample = 2^24-1 → `dout` = 2047 (saturated).
- **Continuous input.** 8 contiguous blocks, each with a distinct `s` → 32 contiguous `valid_out` beats with no bubble, `blk_start` every 4th beat, and `s` updating per block.
- **Gapped input.** Random `din_valid` gaps inside blocks → output content identical to the gap-free run. Each output block is contiguous.
- **Reset mid-operation.** Assert `rstn`=0 after beat 2 of a block while the previous block is playing out → outputs 0 next cycle. The following 4 valid beats form a fresh block, and the partial data never appears.
